// File: rtl/dic_load_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dic_load_seq
//  Description : Command/load sequencer for the digital-clock datapath.
//                Parses an ASCII byte stream into run/stop/load commands,
//                issues one-cycle digit-load strobes with ld_num, drives
//                dicRun, and aborts an idle load after TIMEOUT_SEC seconds.
//                Optional byte echo to the UART transmit path is built when
//                the macro DIC_LD_ECHO_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module dic_load_seq #(
    parameter int TIMEOUT_SEC    = 10,
    parameter int RUN_AFTER_LOAD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_char,
    input  logic       i_charValid,
    output logic       o_charReady,
    input  logic       i_oneSecStrb,
    output logic       ldMtens,
    output logic       ldMones,
    output logic       ldStens,
    output logic       ldSones,
    output logic [3:0] ld_num,
    output logic       dicRun,
    output logic       o_loading,
    output logic       o_err,
    output logic [7:0] o_echo,
    output logic       o_echoValid,
    input  logic       i_echoReady
);

    // A zero timeout disables the timer; keep at least one bit of storage.
    localparam int c_TIMER_W = (TIMEOUT_SEC > 0) ? $clog2(TIMEOUT_SEC + 1) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMER_TERM =
        c_TIMER_W'((TIMEOUT_SEC > 0) ? (TIMEOUT_SEC - 1) : 0);
    localparam logic [c_TIMER_W-1:0] c_TIMER_MAX  = c_TIMER_W'(TIMEOUT_SEC);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE  = c_TIMER_W'(1);

    localparam logic [7:0] c_CHAR_R     = 8'h52;
    localparam logic [7:0] c_CHAR_S     = 8'h53;
    localparam logic [7:0] c_CHAR_L     = 8'h4C;
    localparam logic [7:0] c_CHAR_COLON = 8'h3A;
    localparam logic [7:0] c_CHAR_ESC   = 8'h1B;
    localparam logic [7:0] c_CHAR_QUERY = 8'h3F;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_STOP  = 3'd1,
        ST_LD_MT = 3'd2,
        ST_LD_MO = 3'd3,
        ST_LD_ST = 3'd4,
        ST_LD_SO = 3'd5
    } stateT;

    stateT                r_state;
    stateT                w_stateNext;
    logic                 r_retRun;        // 1: abort/escape returns to RUN, 0: to STOP
    logic                 w_retRunNext;
    logic [c_TIMER_W-1:0] r_timer;
    logic [c_TIMER_W-1:0] w_timerNext;
    logic [3:0]           r_ldSel;         // one-hot {Mtens, Mones, Stens, Sones}
    logic [3:0]           w_ldSelNext;
    logic [3:0]           r_ldNum;
    logic [3:0]           w_ldNumNext;
    logic                 r_err;
    logic                 w_reject;

    logic                 w_accept;
    logic                 w_inLoad;
    logic                 w_timeout;
    logic [7:0]           w_charUp;
    logic                 w_isDigit;
    logic                 w_digitOk;
    stateT                w_retState;
    stateT                w_doneState;

    assign w_accept    = i_charValid & o_charReady;
    assign w_inLoad    = (r_state == ST_LD_MT) || (r_state == ST_LD_MO) ||
                         (r_state == ST_LD_ST) || (r_state == ST_LD_SO);
    assign w_charUp    = ((i_char >= 8'h61) && (i_char <= 8'h7A)) ? (i_char - 8'h20) : i_char;
    assign w_isDigit   = (i_char >= 8'h30) && (i_char <= 8'h39);
    // Tens positions only take 0-5; ones positions take 0-9.
    assign w_digitOk   = ((r_state == ST_LD_MT) || (r_state == ST_LD_ST)) ? (i_char <= 8'h35) : 1'b1;
    assign w_retState  = r_retRun ? ST_RUN : ST_STOP;
    assign w_doneState = (RUN_AFTER_LOAD != 0) ? ST_RUN : ST_STOP;

    // Terminal idle strobe aborts the load unless a byte is accepted in the same cycle.
    assign w_timeout   = (TIMEOUT_SEC != 0) && w_inLoad && i_oneSecStrb && !w_accept &&
                         (r_timer == c_TIMER_TERM);

    // State, return mode, idle timer and registered strobe/error outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_RUN;
            r_retRun <= 1'b1;
            r_timer  <= '0;
            r_ldSel  <= 4'b0000;
            r_ldNum  <= 4'd0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_retRun <= w_retRunNext;
            r_timer  <= w_timerNext;
            r_ldSel  <= w_ldSelNext;
            r_ldNum  <= w_ldNumNext;
            r_err    <= w_reject | w_timeout;
        end
    end

    // Command parsing, load sequencing and idle-timer next values.
    always_comb begin
        w_stateNext  = r_state;
        w_retRunNext = r_retRun;
        w_ldSelNext  = 4'b0000;
        w_ldNumNext  = r_ldNum;
        w_reject     = 1'b0;
        w_timerNext  = r_timer;

        // Timer runs only inside a load and restarts on any accepted byte.
        if (!w_inLoad || w_accept) begin
            w_timerNext = '0;
        end else if (i_oneSecStrb && (r_timer != c_TIMER_MAX)) begin
            w_timerNext = r_timer + c_TIMER_ONE;
        end

        if (w_accept) begin
            if (!w_inLoad) begin
                if (w_charUp == c_CHAR_R) begin
                    w_stateNext = ST_RUN;
                end else if (w_charUp == c_CHAR_S) begin
                    w_stateNext = ST_STOP;
                end else if (w_charUp == c_CHAR_L) begin
                    w_stateNext  = ST_LD_MT;
                    w_retRunNext = (r_state == ST_RUN);
                end else begin
                    w_reject = 1'b1;
                end
            end else begin
                if (w_isDigit && w_digitOk) begin
                    // ASCII digit minus 8'h30 is simply the low nibble.
                    w_ldNumNext = i_char[3:0];
                    case (r_state)
                        ST_LD_MT: begin
                            w_ldSelNext = 4'b1000;
                            w_stateNext = ST_LD_MO;
                        end
                        ST_LD_MO: begin
                            w_ldSelNext = 4'b0100;
                            w_stateNext = ST_LD_ST;
                        end
                        ST_LD_ST: begin
                            w_ldSelNext = 4'b0010;
                            w_stateNext = ST_LD_SO;
                        end
                        default: begin
                            w_ldSelNext = 4'b0001;
                            w_stateNext = w_doneState;
                        end
                    endcase
                end else if (i_char == c_CHAR_COLON) begin
                    w_stateNext = r_state;
                end else if (w_charUp == c_CHAR_L) begin
                    w_stateNext = ST_LD_MT;
                end else if (i_char == c_CHAR_ESC) begin
                    w_stateNext = w_retState;
                end else begin
                    // Hold the position so the user can retry the digit.
                    w_reject = 1'b1;
                end
            end
        end else if (w_timeout) begin
            w_stateNext = w_retState;
        end
    end

    assign ldMtens   = r_ldSel[3];
    assign ldMones   = r_ldSel[2];
    assign ldStens   = r_ldSel[1];
    assign ldSones   = r_ldSel[0];
    assign ld_num    = r_ldNum;
    assign o_err     = r_err;
    assign dicRun    = (r_state == ST_RUN);
    assign o_loading = w_inLoad;

`ifdef DIC_LD_ECHO_EN
    logic       r_echoValid;
    logic [7:0] r_echo;

    // One-deep echo buffer; input is back-pressured while it is full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_echoValid <= 1'b0;
            r_echo      <= 8'h00;
        end else if (w_accept) begin
            r_echoValid <= 1'b1;
            r_echo      <= w_reject ? c_CHAR_QUERY : i_char;
        end else if (r_echoValid && i_echoReady) begin
            r_echoValid <= 1'b0;
        end
    end

    assign o_charReady = !r_echoValid;
    assign o_echoValid = r_echoValid;
    assign o_echo      = r_echo;
`else
    logic w_unusedEchoReady;

    assign w_unusedEchoReady = i_echoReady;
    assign o_charReady       = 1'b1;
    assign o_echoValid       = 1'b0;
    assign o_echo            = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dic_load_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dic_load_seq
//  Description : Directed self-checking bench for dic_load_seq. Echo checks
//                follow whichever build DIC_LD_ECHO_EN selects.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dic_load_seq;

    logic       clk;
    logic       rst;
    logic [7:0] i_char;
    logic       i_charValid;
    logic       o_charReady;
    logic       i_oneSecStrb;
    logic       ldMtens;
    logic       ldMones;
    logic       ldStens;
    logic       ldSones;
    logic [3:0] ld_num;
    logic       dicRun;
    logic       o_loading;
    logic       o_err;
    logic [7:0] o_echo;
    logic       o_echoValid;
    logic       i_echoReady;

    int checks;
    int failures;

    logic [3:0] ldVec;
    assign ldVec = {ldMtens, ldMones, ldStens, ldSones};

    dic_load_seq #(
        .TIMEOUT_SEC   (10),
        .RUN_AFTER_LOAD(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_char      (i_char),
        .i_charValid (i_charValid),
        .o_charReady (o_charReady),
        .i_oneSecStrb(i_oneSecStrb),
        .ldMtens     (ldMtens),
        .ldMones     (ldMones),
        .ldStens     (ldStens),
        .ldSones     (ldSones),
        .ld_num      (ld_num),
        .dicRun      (dicRun),
        .o_loading   (o_loading),
        .o_err       (o_err),
        .o_echo      (o_echo),
        .o_echoValid (o_echoValid),
        .i_echoReady (i_echoReady)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one byte (optionally with a coincident second strobe); return 1ns after the accept edge.
    task automatic sendByte(input logic [7:0] c, input logic strb);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_charReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout got o_charReady=%0b want 1", o_charReady);
        end
        i_char       = c;
        i_charValid  = 1'b1;
        i_oneSecStrb = strb;
        @(posedge clk);
        #1;
        i_charValid  = 1'b0;
        i_oneSecStrb = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_oneSecStrb = 1'b1;
            @(posedge clk);
            #1;
            i_oneSecStrb = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2 rst = 1'b0;
        idle(3);
        checks++; if (dicRun !== 1'b1) begin failures++; $display("FAIL reset_dicRun got=%0b want=1", dicRun); end
        checks++; if (ldVec !== 4'b0000) begin failures++; $display("FAIL reset_ld got=%b want=0000", ldVec); end
        checks++; if (ld_num !== 4'd0) begin failures++; $display("FAIL reset_ldnum got=%0d want=0", ld_num); end
        checks++; if (o_err !== 1'b0 || o_loading !== 1'b0) begin failures++; $display("FAIL reset_err_loading got=%0b%0b want=00", o_err, o_loading); end
        checks++; if (o_echoValid !== 1'b0) begin failures++; $display("FAIL reset_echoValid got=%0b want=0", o_echoValid); end
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        checks++; if (dicRun !== 1'b1) begin failures++; $display("FAIL release_dicRun got=%0b want=1", dicRun); end
    endtask

    task automatic test_run_stop;
        sendByte(8'h53, 1'b0);  // 'S'
        checks++; if (dicRun !== 1'b0) begin failures++; $display("FAIL stop_dicRun got=%0b want=0", dicRun); end
        sendByte(8'h72, 1'b0);  // 'r'
        checks++; if (dicRun !== 1'b1) begin failures++; $display("FAIL run_dicRun got=%0b want=1", dicRun); end
        sendByte(8'h78, 1'b0);  // 'x'
        checks++; if (o_err !== 1'b1 || dicRun !== 1'b1) begin failures++; $display("FAIL cmd_reject got err=%0b run=%0b want 1 1", o_err, dicRun); end
        idle(1);
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL err_pulse_width got=%0b want=0", o_err); end
    endtask

    task automatic test_load_seq;
        sendByte(8'h4C, 1'b0);  // 'L'
        checks++; if (o_loading !== 1'b1 || dicRun !== 1'b0) begin failures++; $display("FAIL load_enter got load=%0b run=%0b want 1 0", o_loading, dicRun); end
        sendByte(8'h31, 1'b0);
        checks++; if (ldVec !== 4'b1000 || ld_num !== 4'd1) begin failures++; $display("FAIL ld_mtens got=%b/%0d want=1000/1", ldVec, ld_num); end
        sendByte(8'h32, 1'b0);
        checks++; if (ldVec !== 4'b0100 || ld_num !== 4'd2) begin failures++; $display("FAIL ld_mones got=%b/%0d want=0100/2", ldVec, ld_num); end
        sendByte(8'h3A, 1'b0);  // ':'
        checks++; if (ldVec !== 4'b0000 || o_err !== 1'b0 || o_loading !== 1'b1) begin failures++; $display("FAIL colon got ld=%b err=%0b load=%0b want 0000 0 1", ldVec, o_err, o_loading); end
        sendByte(8'h33, 1'b0);
        checks++; if (ldVec !== 4'b0010 || ld_num !== 4'd3) begin failures++; $display("FAIL ld_stens got=%b/%0d want=0010/3", ldVec, ld_num); end
        sendByte(8'h34, 1'b0);
        checks++; if (ldVec !== 4'b0001 || ld_num !== 4'd4) begin failures++; $display("FAIL ld_sones got=%b/%0d want=0001/4", ldVec, ld_num); end
        checks++; if (dicRun !== 1'b1 || o_loading !== 1'b0) begin failures++; $display("FAIL load_done got run=%0b load=%0b want 1 0", dicRun, o_loading); end
        idle(1);
        checks++; if (ldVec !== 4'b0000 || ld_num !== 4'd4) begin failures++; $display("FAIL ld_hold got=%b/%0d want=0000/4", ldVec, ld_num); end
    endtask

    task automatic test_bad_digit;
        sendByte(8'h4C, 1'b0);
        sendByte(8'h37, 1'b0);  // '7' invalid for tens of minutes
        checks++; if (o_err !== 1'b1 || ldVec !== 4'b0000 || o_loading !== 1'b1) begin failures++; $display("FAIL bad_digit got err=%0b ld=%b load=%0b want 1 0000 1", o_err, ldVec, o_loading); end
        sendByte(8'h35, 1'b0);
        checks++; if (ldVec !== 4'b1000 || ld_num !== 4'd5 || o_err !== 1'b0) begin failures++; $display("FAIL retry_digit got=%b/%0d err=%0b want=1000/5 0", ldVec, ld_num, o_err); end
        sendByte(8'h1B, 1'b0);
        checks++; if (dicRun !== 1'b1 || o_loading !== 1'b0) begin failures++; $display("FAIL esc_run got run=%0b load=%0b want 1 0", dicRun, o_loading); end
    endtask

    task automatic test_timeout;
        sendByte(8'h53, 1'b0);
        sendByte(8'h4C, 1'b0);
        sendByte(8'h33, 1'b0);
        tick(9);
        checks++; if (o_loading !== 1'b1 || o_err !== 1'b0) begin failures++; $display("FAIL pre_timeout got load=%0b err=%0b want 1 0", o_loading, o_err); end
        tick(1);
        checks++; if (o_err !== 1'b1 || o_loading !== 1'b0 || dicRun !== 1'b0) begin failures++; $display("FAIL timeout got err=%0b load=%0b run=%0b want 1 0 0", o_err, o_loading, dicRun); end
        sendByte(8'h6C, 1'b0);  // 'l'
        tick(9);
        sendByte(8'h3A, 1'b1);  // byte coincides with terminal strobe
        checks++; if (o_loading !== 1'b1 || o_err !== 1'b0) begin failures++; $display("FAIL byte_wins got load=%0b err=%0b want 1 0", o_loading, o_err); end
        tick(9);
        checks++; if (o_loading !== 1'b1 || o_err !== 1'b0) begin failures++; $display("FAIL timer_cleared got load=%0b err=%0b want 1 0", o_loading, o_err); end
        tick(1);
        checks++; if (o_err !== 1'b1 || dicRun !== 1'b0 || o_loading !== 1'b0) begin failures++; $display("FAIL timeout2 got err=%0b run=%0b load=%0b want 1 0 0", o_err, dicRun, o_loading); end
        sendByte(8'h52, 1'b0);
    endtask

    task automatic test_escape_reset;
        sendByte(8'h4C, 1'b0);
        sendByte(8'h34, 1'b0);
        checks++; if (ldVec !== 4'b1000 || ld_num !== 4'd4) begin failures++; $display("FAIL esc_load got=%b/%0d want=1000/4", ldVec, ld_num); end
        sendByte(8'h1B, 1'b0);
        checks++; if (ldVec !== 4'b0000 || dicRun !== 1'b1 || o_loading !== 1'b0 || ld_num !== 4'd4) begin failures++; $display("FAIL esc_return got ld=%b run=%0b load=%0b num=%0d want 0000 1 0 4", ldVec, dicRun, o_loading, ld_num); end
        sendByte(8'h4C, 1'b0);
        sendByte(8'h31, 1'b0);
        sendByte(8'h32, 1'b0);
        @(negedge clk);
        i_char      = 8'h33;
        i_charValid = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++; if (dicRun !== 1'b1 || o_loading !== 1'b0 || ldVec !== 4'b0000 || ld_num !== 4'd0) begin failures++; $display("FAIL mid_reset got run=%0b load=%0b ld=%b num=%0d want 1 0 0000 0", dicRun, o_loading, ldVec, ld_num); end
        i_charValid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (ldVec !== 4'b0000) begin failures++; $display("FAIL no_partial_strobe got=%b want=0000", ldVec); end
        @(negedge clk);
        rst = 1'b1;
        idle(1);
    endtask

    task automatic test_echo;
`ifdef DIC_LD_ECHO_EN
        @(negedge clk);
        i_echoReady = 1'b0;
        sendByte(8'h53, 1'b0);
        checks++; if (o_echoValid !== 1'b1 || o_echo !== 8'h53 || o_charReady !== 1'b0) begin failures++; $display("FAIL echo_s got v=%0b e=%h r=%0b want 1 53 0", o_echoValid, o_echo, o_charReady); end
        idle(2);
        checks++; if (o_echoValid !== 1'b1 || o_charReady !== 1'b0) begin failures++; $display("FAIL echo_hold got v=%0b r=%0b want 1 0", o_echoValid, o_charReady); end
        @(negedge clk);
        i_echoReady = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (o_echoValid !== 1'b0 || o_charReady !== 1'b1) begin failures++; $display("FAIL echo_drain got v=%0b r=%0b want 0 1", o_echoValid, o_charReady); end
        sendByte(8'h78, 1'b0);
        checks++; if (o_echo !== 8'h3F || o_err !== 1'b1 || o_echoValid !== 1'b1) begin failures++; $display("FAIL echo_reject got e=%h err=%0b v=%0b want 3f 1 1", o_echo, o_err, o_echoValid); end
`else
        @(negedge clk);
        i_echoReady = 1'b0;
        sendByte(8'h53, 1'b0);
        checks++; if (o_charReady !== 1'b1 || o_echoValid !== 1'b0 || o_echo !== 8'h00) begin failures++; $display("FAIL no_echo got r=%0b v=%0b e=%h want 1 0 00", o_charReady, o_echoValid, o_echo); end
        checks++; if (dicRun !== 1'b0) begin failures++; $display("FAIL no_echo_stop got=%0b want=0", dicRun); end
        i_echoReady = 1'b1;
`endif
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        i_char       = 8'h00;
        i_charValid  = 1'b0;
        i_oneSecStrb = 1'b0;
        i_echoReady  = 1'b1;
        test_reset();
        test_run_stop();
        test_load_seq();
        test_bad_digit();
        test_timeout();
        test_escape_reset();
        test_echo();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
